// File: rtl/alu_issue_seq_pkg.sv
// Shared types for the ALU issue sequencer: opcodes, FSM states, flag layout, instruction payload.
// Optional build macro: SEQ_CARRY_CHAIN_EN (feeds the last carry flag back as alu_carry_in).
package alu_issue_seq_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_AW = 2;
    localparam int unsigned NREGS  = 4;
    localparam int unsigned FLAG_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_INVALID   = 4'd0,
        OP_ADD       = 4'd1,
        OP_ADD_CARRY = 4'd2,
        OP_SUB       = 4'd3,
        OP_AND       = 4'd4,
        OP_OR        = 4'd5,
        OP_XOR       = 4'd6,
        OP_NOT       = 4'd7,
        OP_ROL       = 4'd8,
        OP_ROR       = 4'd9
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_e;

    // Bit order matches the flags port: {parity,zero,borrow,carry,invalid}
    typedef struct packed {
        logic parity;
        logic zero;
        logic borrow;
        logic carry;
        logic invalid;
    } flags_t;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } instr_t;

endpackage

// File: rtl/alu_issue_seq_regfile.sv
// 4-entry register file: writeback and host write ports (writeback wins on same address), 3 async reads.
module alu_issue_seq_regfile
    import alu_issue_seq_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wb_en,
    input  logic [REG_AW-1:0]    wb_addr,
    input  logic [BUS_WIDTH-1:0] wb_data,
    input  logic                 ext_en,
    input  logic [REG_AW-1:0]    ext_addr,
    input  logic [BUS_WIDTH-1:0] ext_data,
    input  logic [REG_AW-1:0]    rs1_addr,
    input  logic [REG_AW-1:0]    rs2_addr,
    input  logic [REG_AW-1:0]    rd_addr,
    output logic [BUS_WIDTH-1:0] rs1_data_c,
    output logic [BUS_WIDTH-1:0] rs2_data_c,
    output logic [BUS_WIDTH-1:0] rd_data_c
);

    logic [BUS_WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wb_en && (wb_addr == REG_AW'(i))) begin
                    mem[i] <= wb_data;
                end else if (ext_en && (ext_addr == REG_AW'(i))) begin
                    mem[i] <= ext_data;
                end
            end
        end
    end

    assign rs1_data_c = mem[rs1_addr];
    assign rs2_data_c = mem[rs2_addr];
    assign rd_data_c  = mem[rd_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue stage in front of the combinational ALU: IDLE -> ISSUE -> WB, one instruction per 3 cycles.
// Optional build macro: SEQ_CARRY_CHAIN_EN (alu_carry_in taken from the last completed carry flag).
module alu_issue_seq
    import alu_issue_seq_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [OP_W-1:0]      instr_opcode,
    input  logic [REG_AW-1:0]    instr_rd,
    input  logic [REG_AW-1:0]    instr_rs1,
    input  logic [REG_AW-1:0]    instr_rs2,
    input  logic                 ext_wr_en,
    input  logic [REG_AW-1:0]    ext_wr_addr,
    input  logic [BUS_WIDTH-1:0] ext_wr_data,
    input  logic [REG_AW-1:0]    rd_addr,
    output logic [BUS_WIDTH-1:0] rd_data,
    output logic [OP_W-1:0]      alu_opcode,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic                 alu_carry_in,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic                 alu_carry_out,
    input  logic                 alu_borrow,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    input  logic                 alu_invalid_op,
    output logic [FLAG_W-1:0]    flags,
    output logic                 done,
    output logic                 err
);

    state_e               state, state_nxt;
    instr_t               instr_c;
    flags_t               flags_q, flags_nxt;
    logic [REG_AW-1:0]    rd_q, rd_nxt;
    logic [OP_W-1:0]      opcode_nxt;
    logic [BUS_WIDTH-1:0] a_nxt, b_nxt;
    logic                 cin_nxt, done_nxt, err_nxt;
    logic                 cin_sel_c, wb_en_c;
    logic [BUS_WIDTH-1:0] rs1_data_c, rs2_data_c;

    assign instr_c = '{opcode: instr_opcode, rd: instr_rd, rs1: instr_rs1, rs2: instr_rs2};

`ifdef SEQ_CARRY_CHAIN_EN
    assign cin_sel_c = flags_q.carry;
`else
    assign cin_sel_c = 1'b0;
`endif

    alu_issue_seq_regfile #(.BUS_WIDTH(BUS_WIDTH)) u_regfile (
        .clk        (clk),
        .reset_n    (reset_n),
        .wb_en      (wb_en_c),
        .wb_addr    (rd_q),
        .wb_data    (alu_y),
        .ext_en     (ext_wr_en),
        .ext_addr   (ext_wr_addr),
        .ext_data   (ext_wr_data),
        .rs1_addr   (instr_c.rs1),
        .rs2_addr   (instr_c.rs2),
        .rd_addr    (rd_addr),
        .rs1_data_c (rs1_data_c),
        .rs2_data_c (rs2_data_c),
        .rd_data_c  (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            rd_q         <= '0;
            alu_opcode   <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_carry_in <= 1'b0;
            flags_q      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            rd_q         <= rd_nxt;
            alu_opcode   <= opcode_nxt;
            alu_a        <= a_nxt;
            alu_b        <= b_nxt;
            alu_carry_in <= cin_nxt;
            flags_q      <= flags_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_nxt  = state;
        rd_nxt     = rd_q;
        opcode_nxt = alu_opcode;
        a_nxt      = alu_a;
        b_nxt      = alu_b;
        cin_nxt    = alu_carry_in;
        flags_nxt  = flags_q;
        done_nxt   = 1'b0;
        err_nxt    = err;
        wb_en_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_nxt  = ST_ISSUE;
                    rd_nxt     = instr_c.rd;
                    opcode_nxt = instr_c.opcode;
                    a_nxt      = rs1_data_c;
                    b_nxt      = rs2_data_c;
                    cin_nxt    = cin_sel_c;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WB;
            end
            ST_WB: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
                if (alu_invalid_op) begin
                    flags_nxt.invalid = 1'b1;
                    err_nxt           = 1'b1;
                end else begin
                    wb_en_c          = 1'b1;
                    flags_nxt.parity = alu_parity;
                    flags_nxt.zero   = alu_zero;
                    flags_nxt.borrow = alu_borrow;
                    flags_nxt.carry  = alu_carry_out;
                    flags_nxt.invalid = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign instr_ready = (state == ST_IDLE);
    assign flags       = flags_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU stub, register-array reference model, directed + random steps.
module tb_alu_issue_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [3:0]   instr_opcode = '0;
    logic [1:0]   instr_rd = '0;
    logic [1:0]   instr_rs1 = '0;
    logic [1:0]   instr_rs2 = '0;
    logic         ext_wr_en = 1'b0;
    logic [1:0]   ext_wr_addr = '0;
    logic [W-1:0] ext_wr_data = '0;
    logic [1:0]   rd_addr = '0;
    logic [W-1:0] rd_data;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_a, alu_b;
    logic         alu_carry_in;
    logic [W-1:0] alu_y;
    logic         alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
    logic [4:0]   flags;
    logic         done, err;

    typedef struct packed {
        logic [W-1:0] y;
        logic c, bo, z, p, inv;
    } alu_res_t;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_reg [4];
    logic [4:0]   m_flags;
    logic         m_err;

    always #5 clk = ~clk;

    alu_issue_seq #(.BUS_WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
        .alu_y(alu_y), .alu_carry_out(alu_carry_out), .alu_borrow(alu_borrow),
        .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_invalid_op(alu_invalid_op),
        .flags(flags), .done(done), .err(err)
    );

    // Behavioural ALU: opcodes 1..9 defined, everything else invalid
    function automatic alu_res_t alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic cin);
        alu_res_t r;
        int unsigned s;
        r = '0;
        case (op)
            4'd1: begin s = int'(a) + int'(b); r.y = W'(s); r.c = (s > 255); end
            4'd2: begin s = int'(a) + int'(b) + int'(cin); r.y = W'(s); r.c = (s > 255); end
            4'd3: begin r.y = a - b; r.bo = (a < b); end
            4'd4: r.y = a & b;
            4'd5: r.y = a | b;
            4'd6: r.y = a ^ b;
            4'd7: r.y = ~a;
            4'd8: r.y = {a[W-2:0], a[W-1]};
            4'd9: r.y = {a[0], a[W-1:1]};
            default: r.inv = 1'b1;
        endcase
        if (!r.inv) begin
            r.z = (r.y == '0);
            r.p = ^r.y;
        end
        return r;
    endfunction

    alu_res_t stub;
    assign stub           = alu_fn(alu_opcode, alu_a, alu_b, alu_carry_in);
    assign alu_y          = stub.y;
    assign alu_carry_out  = stub.c;
    assign alu_borrow     = stub.bo;
    assign alu_zero       = stub.z;
    assign alu_parity     = stub.p;
    assign alu_invalid_op = stub.inv;

    function automatic logic exp_cin();
`ifdef SEQ_CARRY_CHAIN_EN
        return m_flags[1];
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_write(input logic [1:0] a, input logic [W-1:0] d);
        ext_wr_en = 1'b1; ext_wr_addr = a; ext_wr_data = d;
        tick();
        ext_wr_en = 1'b0;
        m_reg[a] = d;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            chk(tag, 32'(rd_data), 32'(m_reg[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_flags = '0;
        m_err = 1'b0;
    endtask

    task automatic apply_result(input alu_res_t e, input logic [1:0] rd,
                                input bit collide, input logic [W-1:0] cdata);
        if (e.inv) begin
            m_flags[0] = 1'b1;
            m_err = 1'b1;
            if (collide) m_reg[rd] = cdata;
        end else begin
            m_reg[rd] = e.y;
            m_flags = {e.p, e.z, e.bo, e.c, 1'b0};
        end
    endtask

    // One instruction from IDLE through writeback; optional host write to rd on the WB edge
    task automatic run_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input bit collide, input logic [W-1:0] cdata);
        alu_res_t e;
        logic cin;
        chk("ready_idle", 32'(instr_ready), 32'(1));
        cin = exp_cin();
        e = alu_fn(op, m_reg[rs1], m_reg[rs2], cin);
        instr_valid = 1'b1; instr_opcode = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        tick();
        instr_valid = 1'b0;
        chk("issue_opcode", 32'(alu_opcode), 32'(op));
        chk("issue_a", 32'(alu_a), 32'(m_reg[rs1]));
        chk("issue_b", 32'(alu_b), 32'(m_reg[rs2]));
        chk("issue_cin", 32'(alu_carry_in), 32'(cin));
        chk("issue_ready", 32'(instr_ready), 32'(0));
        chk("issue_done", 32'(done), 32'(0));
        tick();
        chk("wb_ready", 32'(instr_ready), 32'(0));
        chk("wb_done", 32'(done), 32'(0));
        if (collide) begin
            ext_wr_en = 1'b1; ext_wr_addr = rd; ext_wr_data = cdata;
        end
        tick();
        ext_wr_en = 1'b0;
        apply_result(e, rd, collide, cdata);
        chk("done_pulse", 32'(done), 32'(1));
        chk("flags", 32'(flags), 32'(m_flags));
        chk("err", 32'(err), 32'(m_err));
        chk("ready_after", 32'(instr_ready), 32'(1));
        rd_addr = rd;
        #1;
        chk("rd_result", 32'(rd_data), 32'(m_reg[rd]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int acc;
        alu_res_t e;
        model_reset();

        // Reset values while held in reset
        #3;
        chk("rst_opcode", 32'(alu_opcode), 32'(0));
        chk("rst_a", 32'(alu_a), 32'(0));
        chk("rst_flags", 32'(flags), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        reset_n = 1'b1;
        tick();
        chk("rst_ready", 32'(instr_ready), 32'(1));

        // Reset asserted while an ADD is in ISSUE: nothing completes
        ext_write(2'd0, 8'd5);
        ext_write(2'd1, 8'd7);
        instr_valid = 1'b1; instr_opcode = 4'd1; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd1;
        tick();
        instr_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_opcode", 32'(alu_opcode), 32'(0));
        chk("midrst_a", 32'(alu_a), 32'(0));
        chk("midrst_b", 32'(alu_b), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        chk("midrst_ready", 32'(instr_ready), 32'(1));
        chk("midrst_nodone0", 32'(done), 32'(0));
        tick();
        chk("midrst_nodone1", 32'(done), 32'(0));
        check_regs("midrst_reg");

        // Plain ADD
        ext_write(2'd0, 8'd9);
        ext_write(2'd1, 8'd33);
        run_instr(4'd1, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0);
        chk("add_42", 32'(rd_data), 32'(42));
        chk("add_carry", 32'(flags[1]), 32'(0));
        chk("add_zero", 32'(flags[3]), 32'(0));

        // Overflowing ADD then ADD_CARRY
        ext_write(2'd0, 8'd255);
        ext_write(2'd1, 8'd1);
        run_instr(4'd1, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0);
        chk("ovf_result", 32'(rd_data), 32'(0));
        chk("ovf_zero", 32'(flags[3]), 32'(1));
        chk("ovf_carry", 32'(flags[1]), 32'(1));
        ext_write(2'd0, 8'd9);
        ext_write(2'd1, 8'd33);
        run_instr(4'd2, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0);
`ifdef SEQ_CARRY_CHAIN_EN
        chk("addc_result", 32'(rd_data), 32'(43));
`else
        chk("addc_result", 32'(rd_data), 32'(42));
`endif

        // SUB with and without borrow
        ext_write(2'd0, 8'd65);
        ext_write(2'd1, 8'd66);
        run_instr(4'd3, 2'd3, 2'd0, 2'd1, 1'b0, 8'd0);
        chk("sub_255", 32'(rd_data), 32'(255));
        chk("sub_borrow1", 32'(flags[2]), 32'(1));
        ext_write(2'd1, 8'd64);
        run_instr(4'd3, 2'd3, 2'd0, 2'd1, 1'b0, 8'd0);
        chk("sub_1", 32'(rd_data), 32'(1));
        chk("sub_borrow0", 32'(flags[2]), 32'(0));

        // Invalid opcode: no write, sticky err
        run_instr(4'd0, 2'd3, 2'd0, 2'd1, 1'b0, 8'd0);
        chk("inv_noreg", 32'(rd_data), 32'(1));
        chk("inv_flag", 32'(flags[0]), 32'(1));
        chk("inv_err", 32'(err), 32'(1));
        run_instr(4'd6, 2'd1, 2'd0, 2'd3, 1'b0, 8'd0);
        chk("err_sticky", 32'(err), 32'(1));

        // Host write to rd on the WB edge loses
        ext_write(2'd0, 8'd20);
        ext_write(2'd1, 8'd22);
        run_instr(4'd1, 2'd2, 2'd0, 2'd1, 1'b1, 8'hA5);
        chk("collide_wb_wins", 32'(rd_data), 32'(42));

        // instr_valid held: one accept every 3 cycles
        acc = 0;
        instr_valid = 1'b1; instr_opcode = 4'd1; instr_rd = 2'd3; instr_rs1 = 2'd3; instr_rs2 = 2'd1;
        for (int c = 0; c < 9; c++) begin
            if (instr_ready) begin
                acc++;
                e = alu_fn(4'd1, m_reg[3], m_reg[1], exp_cin());
                apply_result(e, 2'd3, 1'b0, 8'd0);
            end
            tick();
        end
        instr_valid = 1'b0;
        chk("held_accepts", 32'(acc), 32'(3));
        chk("held_done", 32'(done), 32'(1));
        chk("held_flags", 32'(flags), 32'(m_flags));
        check_regs("held_reg");

        // Randomized instruction mix
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0)
                ext_write(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            run_instr(4'($urandom_range(0, 10)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
        end
        check_regs("final_reg");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
